// File: rtl/ball_dir_ctrl.sv
// rtl/ball_dir_ctrl.sv - ball step-rate generator, direction owner and serve/run/lost sequencer
module ball_dir_ctrl #(
    parameter int TICK_DIV  = 833333,
    parameter int CNT_W     = 20,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 156,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 116,
    parameter int PADDLE_Y  = 110,
    parameter int PADDLE_W  = 16,
    parameter int BALL_SIZE = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    input  logic [9:0] paddle_x,
    input  logic       brick_hit,
    input  logic       brick_side,
    output logic       move_en,
    output logic       x_du,
    output logic       y_du,
    output logic       ball_lost,
    output logic       running
);

    // Last count value of one step period; TICK_DIV == 2^CNT_W maps to all ones.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // Geometry constants widened to 11 bits so sums near 1023 do not wrap.
    localparam logic [10:0] L_X_MIN    = 11'(X_MIN);
    localparam logic [10:0] L_X_MAX    = 11'(X_MAX);
    localparam logic [10:0] L_Y_MIN    = 11'(Y_MIN);
    localparam logic [10:0] L_Y_MAX    = 11'(Y_MAX);
    localparam logic [10:0] L_PADDLE_Y = 11'(PADDLE_Y);
    localparam logic [10:0] L_PADDLE_W = 11'(PADDLE_W);
    localparam logic [10:0] L_BALL     = 11'(BALL_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_x_du;
    logic             r_y_du;
    logic             w_x_du_nxt;
    logic             w_y_du_nxt;

    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_px;
    logic [10:0] w_bx_far;
    logic [10:0] w_by_far;
    logic [10:0] w_px_far;

    logic w_x_wall;
    logic w_y_top;
    logic w_paddle;
    logic w_lost;
    logic w_brick_x;
    logic w_brick_y;

    assign w_bx     = {1'b0, ball_x};
    assign w_by     = {1'b0, ball_y};
    assign w_px     = {1'b0, paddle_x};
    assign w_bx_far = w_bx + L_BALL;
    assign w_by_far = w_by + L_BALL;
    assign w_px_far = w_px + L_PADDLE_W;

    // Each wall rule is gated by the current direction, so a ball parked
    // against a wall flips once and then stays put.
    assign w_x_wall = (r_x_du  && (w_bx >= L_X_MAX)) ||
                      (!r_x_du && (w_bx <= L_X_MIN));
    assign w_y_top  = !r_y_du && (w_by <= L_Y_MIN);

    // Paddle hit needs downward travel, vertical contact above the lost line
    // and any horizontal overlap between ball and paddle.
    assign w_paddle = r_y_du
                   && (w_by_far >= L_PADDLE_Y)
                   && (w_by < L_Y_MAX)
                   && (w_bx_far > w_px)
                   && (w_bx < w_px_far);

    assign w_lost    = r_y_du && (w_by >= L_Y_MAX) && !w_paddle;
    assign w_brick_x = brick_hit && brick_side;
    assign w_brick_y = brick_hit && !brick_side;

    // State, rate counter and direction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_x_du  <= 1'b1;
            r_y_du  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x_du  <= w_x_du_nxt;
            r_y_du  <= w_y_du_nxt;
        end
    end

    // Next-state, counter and direction decisions; walls/paddle beat bricks
    // per axis, and a lost ball freezes both directions.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_du_nxt  = r_x_du;
        w_y_du_nxt  = r_y_du;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
                if (w_lost) begin
                    w_state_nxt = ST_LOST;
                    w_cnt_nxt   = '0;
                end else begin
                    if (w_x_wall) begin
                        w_x_du_nxt = !r_x_du;
                    end else if (w_brick_x) begin
                        w_x_du_nxt = !r_x_du;
                    end
                    if (w_y_top) begin
                        w_y_du_nxt = 1'b1;
                    end else if (w_paddle) begin
                        w_y_du_nxt = 1'b0;
                    end else if (w_brick_y) begin
                        w_y_du_nxt = !r_y_du;
                    end
                end
            end
            ST_LOST: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_x_du_nxt  = 1'b1;
                w_y_du_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_x_du_nxt  = 1'b1;
                w_y_du_nxt  = 1'b0;
            end
        endcase
    end

    assign move_en   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);
    assign ball_lost = (r_state == ST_LOST);
    assign running   = (r_state == ST_RUN);
    assign x_du      = r_x_du;
    assign y_du      = r_y_du;

endmodule

// File: tb/tb_ball_dir_ctrl.sv
// tb/tb_ball_dir_ctrl.sv - self-checking bench for ball_dir_ctrl
module tb_ball_dir_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [9:0] ball_x = 10'd80;
    logic [9:0] ball_y = 10'd50;
    logic [9:0] paddle_x = 10'd0;
    logic       brick_hit = 1'b0;
    logic       brick_side = 1'b0;
    logic       move_en;
    logic       x_du;
    logic       y_du;
    logic       ball_lost;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode 0 idle, 1 run, 2 lost; run_idx counts RUN cycles from 1.
    int m_mode    = 0;
    int m_run_idx = 0;
    int m_x       = 1;
    int m_y       = 0;

    ball_dir_ctrl #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_x   (paddle_x),
        .brick_hit  (brick_hit),
        .brick_side (brick_side),
        .move_en    (move_en),
        .x_du       (x_du),
        .y_du       (y_du),
        .ball_lost  (ball_lost),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        int bx, by, px, nx, ny;
        bit paddle, lost;
        bx = int'(ball_x);
        by = int'(ball_y);
        px = int'(paddle_x);
        if (!resetn) begin
            m_mode = 0; m_run_idx = 0; m_x = 1; m_y = 0;
            return;
        end
        case (m_mode)
            0: if (start) begin
                m_mode = 1; m_run_idx = 1;
            end
            1: begin
                paddle = (m_y == 1) && (by + 4 >= 110) && (by < 116)
                      && (bx + 4 > px) && (bx < px + 16);
                lost   = (m_y == 1) && (by >= 116) && !paddle;
                if (lost) begin
                    m_mode = 2;
                end else begin
                    nx = m_x;
                    ny = m_y;
                    if (brick_hit && brick_side)  nx = 1 - m_x;
                    if (brick_hit && !brick_side) ny = 1 - m_y;
                    if (m_x == 1 && bx >= 156) nx = 0;
                    if (m_x == 0 && bx <= 0)   nx = 1;
                    if (m_y == 0 && by <= 0)   ny = 1;
                    if (paddle)                ny = 0;
                    m_x = nx;
                    m_y = ny;
                    m_run_idx++;
                end
            end
            default: begin
                m_mode = 0; m_x = 1; m_y = 0;
            end
        endcase
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("x_du", int'(x_du), m_x);
        check("y_du", int'(y_du), m_y);
        check("running", int'(running), int'(m_mode == 1));
        check("ball_lost", int'(ball_lost), int'(m_mode == 2));
        check("move_en", int'(move_en), int'(m_mode == 1 && (m_run_idx % TD) == 0));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // reset and step rate
        resetn = 1'b0;
        steps(2);
        resetn = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        steps(13);

        // right wall held, then left wall
        ball_x = 10'd156;
        steps(3);
        ball_x = 10'd0;
        step();
        ball_x = 10'd80;
        step();

        // top wall to go downward, then paddle hit
        ball_y = 10'd0;
        step();
        paddle_x = 10'd50; ball_x = 10'd47; ball_y = 10'd106;
        step();
        ball_y = 10'd0;
        step();
        ball_x = 10'd46; ball_y = 10'd116;
        steps(3);

        // bricks
        ball_x = 10'd80; ball_y = 10'd50; paddle_x = 10'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        brick_hit = 1'b1; brick_side = 1'b1;
        step();
        brick_side = 1'b0;
        step();
        step();
        ball_y = 10'd0;
        step();
        brick_hit = 1'b0;
        ball_y = 10'd50;
        step();

        // paddle near the top of the 10-bit range
        paddle_x = 10'd1020; ball_x = 10'd1019; ball_y = 10'd106;
        step();
        ball_x = 10'd80; ball_y = 10'd50; paddle_x = 10'd0;
        step();

        // reset in the middle of RUN
        start = 1'b1;
        steps(4);
        start = 1'b0;
        ball_y = 10'd0;
        step();
        ball_y = 10'd50;
        steps(2);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        steps(6);

        // random play
        for (int it = 0; it < 3000; it++) begin
            resetn     = ($urandom_range(0, 199) != 0);
            start      = ($urandom_range(0, 7) == 0);
            brick_hit  = ($urandom_range(0, 5) == 0);
            brick_side = 1'($urandom_range(0, 1));
            paddle_x   = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(0, 150));
            case ($urandom_range(0, 5))
                0:       ball_x = 10'd0;
                1:       ball_x = 10'd156;
                2:       ball_x = 10'(int'(paddle_x) + $urandom_range(0, 22) - 3);
                3:       ball_x = 10'($urandom_range(0, 1023));
                default: ball_x = 10'($urandom_range(1, 155));
            endcase
            case ($urandom_range(0, 4))
                0:       ball_y = 10'd0;
                1:       ball_y = 10'($urandom_range(104, 118));
                2:       ball_y = 10'($urandom_range(0, 1023));
                default: ball_y = 10'($urandom_range(1, 103));
            endcase
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
